line_fill_engine: RTL



---
 rtl/cache_pkg.sv | 20 ++
 rtl/line_word_counter.sv | 39 +++
 rtl/line_fill_engine.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the cache line-fill path.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_REQ,
    RD_WAIT,
    ALLOC
  } fill_state_t;

  function automatic int words_per_block(input int data_width, input int block_size);
    return block_size / (data_width / 8);
  endfunction

  function automatic int offset_width(input int data_width, input int block_size);
    return $clog2(words_per_block(data_width, block_size));
  endfunction

endpackage

// File: rtl/line_word_counter.sv
// Word index within a line (modulo wrap) plus a beat counter flagging the final beat.
module line_word_counter
  import cache_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W:0]   LAST_BEAT = (IDX_W + 1)'(WORDS - 1);
  localparam logic [IDX_W:0]   BEAT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [IDX_W:0] beats;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      beats <= '0;
    end else if (load) begin
      idx   <= load_idx;
      beats <= '0;
    end else if (inc) begin
      idx   <= idx + IDX_ONE;
      beats <= beats + BEAT_ONE;
    end
  end

  assign last = (beats == LAST_BEAT);

endmodule

// File: rtl/line_fill_engine.sv
// Miss-service engine: optional dirty-victim writeback, then word-by-word line fetch.
// Define LINE_FILL_CRITICAL_WORD_FIRST_EN to start the fetch at the missed word.
module line_fill_engine
  import cache_pkg::*;
#(
  parameter  int DATA_WIDTH      = 32,
  parameter  int BLOCK_SIZE      = 32,
  parameter  int ADDRESS_WIDTH   = 32,
  localparam int WORDS_PER_BLOCK = words_per_block(DATA_WIDTH, BLOCK_SIZE),
  localparam int OFFSET_WIDTH    = offset_width(DATA_WIDTH, BLOCK_SIZE),
  localparam int LINE_WIDTH      = WORDS_PER_BLOCK * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_req,
  output logic                     miss_ready,
  input  logic [ADDRESS_WIDTH-1:0] miss_line_address,
  input  logic                     victim_dirty,
  input  logic [ADDRESS_WIDTH-1:0] victim_line_address,
  input  logic [LINE_WIDTH-1:0]    victim_line,
  output logic                     allocate,
  output logic [ADDRESS_WIDTH-1:0] line_address,
  output logic [LINE_WIDTH-1:0]    fetched_line,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;

  fill_state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]    miss_tag_q, victim_tag_q;
  logic [LINE_WIDTH-1:0]   victim_line_q, fetched_line_q;
  logic [OFFSET_WIDTH-1:0] cnt, cnt_load_idx, start_now, start_reg;
  logic                    cnt_load, cnt_inc, cnt_last;
  logic                    accept;
  logic                    unused_offsets;

  assign accept = (state_q == IDLE) && miss_req;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  logic [OFFSET_WIDTH-1:0] miss_off_q;

  always_ff @(posedge clk) begin
    if (accept) miss_off_q <= miss_line_address[OFFSET_WIDTH-1:0];
  end

  assign start_now      = miss_line_address[OFFSET_WIDTH-1:0];
  assign start_reg      = miss_off_q;
  assign unused_offsets = ^victim_line_address[OFFSET_WIDTH-1:0];
`else
  assign start_now      = '0;
  assign start_reg      = '0;
  assign unused_offsets = ^{miss_line_address[OFFSET_WIDTH-1:0],
                            victim_line_address[OFFSET_WIDTH-1:0]};
`endif

  line_word_counter #(
    .WORDS (WORDS_PER_BLOCK),
    .IDX_W (OFFSET_WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_idx (cnt_load_idx),
    .inc      (cnt_inc),
    .idx      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_tag_q     <= '0;
      fetched_line_q <= '0;
    end else begin
      if (accept) miss_tag_q <= miss_line_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
      if ((state_q == RD_WAIT) && mem_rvalid)
        fetched_line_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
    end
  end

  // NOTE: victim storage is a plain datapath register; it is only read after an
  // accept loads it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      victim_tag_q  <= victim_line_address[ADDRESS_WIDTH-1:OFFSET_WIDTH];
      victim_line_q <= victim_line;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_idx = '0;
    cnt_inc      = 1'b0;
    miss_ready   = 1'b0;
    allocate     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) begin
          cnt_load = 1'b1;
          if (victim_dirty) begin
            state_d = WB;
          end else begin
            state_d      = RD_REQ;
            cnt_load_idx = start_now;
          end
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_q, cnt};
        mem_wdata = victim_line_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];
        if (mem_gnt) begin
          if (cnt_last) begin
            state_d      = RD_REQ;
            cnt_load     = 1'b1;
            cnt_load_idx = start_reg;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, cnt};
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          if (cnt_last) begin
            state_d = ALLOC;
          end else begin
            cnt_inc = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      ALLOC: begin
        allocate = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = !miss_ready;
  assign line_address = {miss_tag_q, {OFFSET_WIDTH{1'b0}}};
  assign fetched_line = fetched_line_q;

endmodule
